// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined segmented ripple-carry adder with valid/ready handshake
module add_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("add_pipe: WIDTH must be a positive multiple of SEG");
    end

    logic adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic [SEG:0]     seg;
        logic [WIDTH-1:0] s_next;
        logic             c_msb;

        logic             v_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             o_q;

        if (k == 0) begin : g_first
            assign v_in = in_valid;
            assign a_in = A;
            assign b_in = B;
            assign s_in = '0;
            assign c_in = cin;
        end else begin : g_next
            assign v_in = g_stage[k-1].v_q;
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
        end

        assign seg = {1'b0, a_in[SEG*k +: SEG]} + {1'b0, b_in[SEG*k +: SEG]} + {{SEG{1'b0}}, c_in};

        // Carry into the segment's top bit recovered from its sum bit; only the last stage's
        // value reaches ovf, where it is the carry into the MSB.
        assign c_msb = a_in[SEG*k+SEG-1] ^ b_in[SEG*k+SEG-1] ^ seg[SEG-1];

        // Merge this segment's result into the partial sum passed down from earlier stages
        always_comb begin
            s_next = s_in;
            s_next[SEG*k +: SEG] = seg[SEG-1:0];
        end

        // Stage register: valid moves on every advance, data only when a real operand arrives
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                o_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    a_q <= a_in;
                    b_q <= b_in;
                    s_q <= s_next;
                    c_q <= seg[SEG];
                    o_q <= seg[SEG] ^ c_msb;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign co        = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].o_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

endmodule
